// File: rtl/ram8_stream_ctrl.sv
// Streaming front end for an 8-word RAM: fill mode writes an incoming valid/ready
// stream to addresses 0..7, dump mode sweeps 0..7 and streams the RAM output downstream.
module ram8_stream_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_fill,
    input  logic              start_dump,
    input  logic [WIDTH-1:0]  s_in,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WIDTH-1:0]  m_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [WIDTH-1:0]  ram_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DUMP = 2'b10
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              fill_s;
    logic              dump_s;

    // State, pointer and done-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; a beat at the last address ends the sweep and rewinds ptr
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_fill) begin
                    state_nxt_s = FILL;
                    ptr_nxt_s   = {ADDR_W{1'b0}};
                end else if (start_dump) begin
                    state_nxt_s = DUMP;
                    ptr_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (s_valid) begin
                    if (ptr_r == PTR_LAST) begin
                        state_nxt_s = IDLE;
                        ptr_nxt_s   = {ADDR_W{1'b0}};
                        done_nxt_s  = 1'b1;
                    end else begin
                        ptr_nxt_s = ptr_r + PTR_ONE;
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            DUMP: begin
                if (m_ready) begin
                    if (ptr_r == PTR_LAST) begin
                        state_nxt_s = IDLE;
                        ptr_nxt_s   = {ADDR_W{1'b0}};
                        done_nxt_s  = 1'b1;
                    end else begin
                        ptr_nxt_s = ptr_r + PTR_ONE;
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = {ADDR_W{1'b0}};
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Handshake strobes are masked by reset so no RAM write lands on a reset edge
    assign fill_s      = (state_r == FILL) & ~reset;
    assign dump_s      = (state_r == DUMP) & ~reset;
    assign s_ready     = fill_s;
    assign ram_load    = fill_s & s_valid;
    assign m_valid     = dump_s;
    assign busy        = (state_r != IDLE) & ~reset;
    assign done        = done_r;
    assign m_out       = ram_out;
    assign ram_in      = s_in;
    assign ram_address = ptr_r;

endmodule

// File: tb/tb_ram8_stream_ctrl.sv
// Bench for ram8_stream_ctrl with a behavioural RAM8 attached; expected frame
// contents are tracked from the bench's own accepted stimulus.
module tb_ram8_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_fill;
    logic        start_dump;
    logic [15:0] s_in;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] ram_in;
    logic [2:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;
    logic        done;

    logic [15:0] mem     [8];
    logic [15:0] exp_mem [8];
    logic [15:0] fdata   [8];
    int          errors = 0;
    int          checks = 0;

    ram8_stream_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .start_fill(start_fill), .start_dump(start_dump),
        .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready),
        .m_out(m_out), .m_valid(m_valid), .m_ready(m_ready),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM8: combinational read, write on rising edge when load is high
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_fill(input int nbeats, input logic [15:0] vpat, input bit rnd,
                           input bit both, input bit poke);
        int   idx;
        int   cyc;
        logic v;
        @(negedge clk);
        start_fill = 1'b1;
        start_dump = both;
        #1;
        chk("idle_sready", {31'd0, s_ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start_fill = 1'b0;
        start_dump = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < nbeats && cyc < 200) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : vpat[cyc % 16];
            s_valid    = v;
            s_in       = v ? fdata[idx] : 16'($urandom);
            start_dump = poke && (cyc == 1);
            #1;
            chk("fill_sready", {31'd0, s_ready}, 32'd1);
            chk("fill_mvalid", {31'd0, m_valid}, 32'd0);
            chk("fill_load", {31'd0, ram_load}, {31'd0, v});
            chk("fill_addr", {29'd0, ram_address}, 32'(idx));
            chk("fill_busy", {31'd0, busy}, 32'd1);
            chk("fill_done", {31'd0, done}, 32'd0);
            if (v) begin
                exp_mem[idx] = fdata[idx];
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        s_valid    = 1'b0;
        start_dump = 1'b0;
        if (cyc >= 200) chk("fill_timeout", 32'd1, 32'd0);
        if (nbeats == 8) begin
            #1;
            chk("fill_done_pulse", {31'd0, done}, 32'd1);
            chk("fill_end_busy", {31'd0, busy}, 32'd0);
            chk("fill_end_sready", {31'd0, s_ready}, 32'd0);
            @(negedge clk);
            #1;
            chk("fill_done_clear", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic do_dump(input logic [15:0] rpat, input bit rnd);
        int   idx;
        int   cyc;
        logic r;
        @(negedge clk);
        start_dump = 1'b1;
        #1;
        chk("idle_mvalid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        start_dump = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            r = rnd ? ($urandom_range(0, 2) != 0) : rpat[cyc % 16];
            m_ready = r;
            #1;
            chk("dump_mvalid", {31'd0, m_valid}, 32'd1);
            chk("dump_sready", {31'd0, s_ready}, 32'd0);
            chk("dump_load", {31'd0, ram_load}, 32'd0);
            chk("dump_addr", {29'd0, ram_address}, 32'(idx));
            chk("dump_data", {16'd0, m_out}, {16'd0, exp_mem[idx]});
            chk("dump_done", {31'd0, done}, 32'd0);
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        if (cyc >= 200) chk("dump_timeout", 32'd1, 32'd0);
        #1;
        chk("dump_done_pulse", {31'd0, done}, 32'd1);
        chk("dump_end_busy", {31'd0, busy}, 32'd0);
        chk("dump_end_mvalid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("dump_done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start_fill = 1'b0;
        start_dump = 1'b0;
        s_in       = 16'h0000;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sready", {31'd0, s_ready}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_load", {31'd0, ram_load}, 32'd0);
        chk("rst_addr", {29'd0, ram_address}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed fill then full-rate dump
        fdata[0] = 16'h0000; fdata[1] = 16'hFFFF; fdata[2] = 16'h00FF; fdata[3] = 16'hFF00;
        fdata[4] = 16'h0F0F; fdata[5] = 16'hF0F0; fdata[6] = 16'h3333; fdata[7] = 16'hCCCC;
        do_fill(8, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        do_dump(16'hFFFF, 1'b0);

        // Fill with bubbles on cycles 2 and 5, dump with m_ready toggling
        for (int i = 0; i < 8; i++) fdata[i] = 16'($urandom);
        do_fill(8, 16'b1111_1111_1101_1011, 1'b0, 1'b0, 1'b0);
        do_dump(16'h5555, 1'b0);

        // Both starts together enter FILL; start_dump mid-fill is ignored
        for (int i = 0; i < 8; i++) fdata[i] = 16'($urandom);
        do_fill(8, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        do_dump(16'hFFFF, 1'b0);

        // Reset after three beats: no write on the reset edge, no done
        for (int i = 0; i < 8; i++) fdata[i] = 16'($urandom);
        do_fill(3, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_in    = 16'($urandom);
        #1;
        chk("abort_load", {31'd0, ram_load}, 32'd0);
        chk("abort_sready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_addr", {29'd0, ram_address}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_done2", {31'd0, done}, 32'd0);
        do_dump(16'hFFFF, 1'b0);

        // Randomized valid/ready rounds
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) fdata[i] = 16'($urandom);
            do_fill(8, 16'h0000, 1'b1, 1'b0, 1'b0);
            do_dump(16'h0000, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
